// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - op codes, FSM state encodings and SP reset value for the stack sequencer
package stack_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_WR_HI   = 4'd1;
    localparam state_t ST_WR_LO   = 4'd2;
    localparam state_t ST_WR_ONE  = 4'd3;
    localparam state_t ST_RD_ONE  = 4'd4;
    localparam state_t ST_RD_LO   = 4'd5;
    localparam state_t ST_RD_HI   = 4'd6;
    localparam state_t ST_CAP_LO  = 4'd7;
    localparam state_t ST_CAP_HI  = 4'd8;
    localparam state_t ST_CAP_ONE = 4'd9;

    // Wide enough for any supported AW; users slice off the low AW bits.
    localparam int MAX_AW = 32;
    localparam logic [MAX_AW-1:0] SP_TOP = '1;

endpackage

// File: rtl/stack_seq_if.sv
// rtl/stack_seq_if.sv - request/response and stack RAM signals of the stack sequencer
interface stack_seq_if #(
    parameter int AW  = 10,
    parameter int DW  = 16,
    parameter int PCW = 32
);
    logic           req_valid;
    logic [1:0]     req_op;
    logic [DW-1:0]  req_data;
    logic [PCW-1:0] req_pc;
    logic           req_ready;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_data;
    logic [PCW-1:0] rsp_pc;
    logic           err_ovf;
    logic           err_udf;
    logic           mem_we;
    logic           mem_re;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    modport master (
        output req_valid, req_op, req_data, req_pc, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_pc, err_ovf, err_udf,
               mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_op, req_data, req_pc, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_pc, err_ovf, err_udf,
               mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sp_unit.sv
// rtl/sp_unit.sv - stack pointer and depth counter for a full-descending stack
module sp_unit
    import stack_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc1,
    input  logic          inc2,
    input  logic          dec1,
    input  logic          dec2,
    output logic [AW-1:0] sp,
    output logic [AW:0]   depth
);

    // Popping moves SP up and shrinks depth; pushing does the opposite.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp    <= SP_TOP[AW-1:0];
            depth <= '0;
        end else if (clear) begin
            sp    <= SP_TOP[AW-1:0];
            depth <= '0;
        end else if (inc1) begin
            sp    <= sp + AW'(1);
            depth <= depth - (AW+1)'(1);
        end else if (inc2) begin
            sp    <= sp + AW'(2);
            depth <= depth - (AW+1)'(2);
        end else if (dec1) begin
            sp    <= sp - AW'(1);
            depth <= depth + (AW+1)'(1);
        end else if (dec2) begin
            sp    <= sp - AW'(2);
            depth <= depth + (AW+1)'(2);
        end
    end

endmodule

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - sequences PUSH/POP/CALL/RET onto a full-descending stack RAM
module stack_seq
    import stack_pkg::*;
#(
    parameter int AW  = 10,
    parameter int DW  = 16,
    parameter int PCW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    stack_seq_if.slave    bus,
    output logic [AW-1:0] sp,
    output logic [AW:0]   depth
);

    localparam logic [AW:0] CAP    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] CAP_M2 = CAP - (AW+1)'(2);

    state_t        state;
    logic [DW-1:0] pc_lo_q;
    logic [DW-1:0] rd_lo_q;
    logic          sp_inc1;
    logic          sp_dec1;

    assign bus.req_ready = (state == ST_IDLE);

    // Each write/read state moves SP by one word; flush overrides inside sp_unit.
    assign sp_dec1 = (state == ST_WR_ONE) || (state == ST_WR_HI) || (state == ST_WR_LO);
    assign sp_inc1 = (state == ST_RD_ONE) || (state == ST_RD_LO) || (state == ST_RD_HI);

    sp_unit #(.AW(AW)) u_sp (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc1  (sp_inc1),
        .inc2  (1'b0),
        .dec1  (sp_dec1),
        .dec2  (1'b0),
        .sp    (sp),
        .depth (depth)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            pc_lo_q       <= '0;
            rd_lo_q       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_pc    <= '0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.err_ovf   <= 1'b0;
            bus.err_udf   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_re    <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.req_valid) begin
                            case (bus.req_op)
                                OP_PUSH: begin
                                    if (depth == CAP) begin
                                        bus.err_ovf <= 1'b1;
                                    end else begin
                                        state         <= ST_WR_ONE;
                                        bus.mem_we    <= 1'b1;
                                        bus.mem_addr  <= sp;
                                        bus.mem_wdata <= bus.req_data;
                                    end
                                end
                                OP_CALL: begin
                                    if (depth > CAP_M2) begin
                                        bus.err_ovf <= 1'b1;
                                    end else begin
                                        state         <= ST_WR_HI;
                                        bus.mem_we    <= 1'b1;
                                        bus.mem_addr  <= sp;
                                        bus.mem_wdata <= bus.req_pc[PCW-1:DW];
                                        pc_lo_q       <= bus.req_pc[DW-1:0];
                                    end
                                end
                                OP_POP: begin
                                    if (depth == '0) begin
                                        bus.err_udf <= 1'b1;
                                    end else begin
                                        state        <= ST_RD_ONE;
                                        bus.mem_re   <= 1'b1;
                                        bus.mem_addr <= sp + AW'(1);
                                    end
                                end
                                default: begin
                                    if (depth < (AW+1)'(2)) begin
                                        bus.err_udf <= 1'b1;
                                    end else begin
                                        state        <= ST_RD_LO;
                                        bus.mem_re   <= 1'b1;
                                        bus.mem_addr <= sp + AW'(1);
                                    end
                                end
                            endcase
                        end
                    end
                    ST_WR_HI: begin
                        state         <= ST_WR_LO;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.mem_addr - AW'(1);
                        bus.mem_wdata <= pc_lo_q;
                    end
                    ST_RD_ONE: state <= ST_CAP_ONE;
                    ST_CAP_ONE: begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= bus.mem_rdata;
                    end
                    ST_RD_LO: begin
                        state        <= ST_RD_HI;
                        bus.mem_re   <= 1'b1;
                        bus.mem_addr <= bus.mem_addr + AW'(1);
                    end
                    // Low word of the return PC arrives while the high word is being read.
                    ST_RD_HI: begin
                        state   <= ST_CAP_HI;
                        rd_lo_q <= bus.mem_rdata;
                    end
                    ST_CAP_HI: begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_pc    <= {bus.mem_rdata, rd_lo_q};
                    end
                    ST_WR_LO, ST_WR_ONE, ST_CAP_LO: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - table-driven and scoreboard bench for stack_seq at AW=10 and AW=2
module tb_stack_seq;
    import stack_pkg::*;

    localparam logic [2:0] K_NONE = 3'd0, K_DATA = 3'd1, K_PC = 3'd2, K_OVF = 3'd3, K_UDF = 3'd4;

    typedef struct {
        logic [2:0]  k;
        logic [15:0] d;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d;
        logic [31:0] pc;
        logic [2:0]  ek;
        logic [15:0] ed;
        logic [31:0] ep;
        logic [9:0]  esp;
        logic [10:0] edep;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic [9:0]  sp1;
    logic [10:0] depth1;
    logic [1:0]  sp2;
    logic [2:0]  depth2;
    logic [15:0] ram1 [1024];
    logic [15:0] ram2 [4];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t tbl[14];
    int n_checks = 0;
    int n_pass = 0;

    stack_seq_if #(.AW(10), .DW(16), .PCW(32)) b1 ();
    stack_seq_if #(.AW(2),  .DW(16), .PCW(32)) b2 ();

    stack_seq #(.AW(10), .DW(16), .PCW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(b1), .sp(sp1), .depth(depth1)
    );
    stack_seq #(.AW(2), .DW(16), .PCW(32)) dut2 (
        .clk(clk), .rst(rst), .flush(1'b0), .bus(b2), .sp(sp2), .depth(depth2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_wdata;
        if (b1.mem_re) b1.mem_rdata <= ram1[b1.mem_addr];
        if (b2.mem_we) ram2[b2.mem_addr] <= b2.mem_wdata;
        if (b2.mem_re) b2.mem_rdata <= ram2[b2.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst && (b1.rsp_valid || b1.err_ovf || b1.err_udf)) begin
            if (q1.size() == 0) begin
                n_checks++;
                $display("FAIL sb1_unexpected: got rsp=%b ovf=%b udf=%b expected none",
                         b1.rsp_valid, b1.err_ovf, b1.err_udf);
            end else begin
                e1 = q1.pop_front();
                chk("sb1_rsp_valid", 32'(b1.rsp_valid), 32'(e1.k == K_DATA || e1.k == K_PC));
                chk("sb1_err_ovf", 32'(b1.err_ovf), 32'(e1.k == K_OVF));
                chk("sb1_err_udf", 32'(b1.err_udf), 32'(e1.k == K_UDF));
                if (e1.k == K_DATA) chk("sb1_rsp_data", 32'(b1.rsp_data), 32'(e1.d));
                if (e1.k == K_PC) chk("sb1_rsp_pc", b1.rsp_pc, e1.pc);
            end
        end
        if (rst && (b2.rsp_valid || b2.err_ovf || b2.err_udf)) begin
            if (q2.size() == 0) begin
                n_checks++;
                $display("FAIL sb2_unexpected: got rsp=%b ovf=%b udf=%b expected none",
                         b2.rsp_valid, b2.err_ovf, b2.err_udf);
            end else begin
                e2 = q2.pop_front();
                chk("sb2_rsp_valid", 32'(b2.rsp_valid), 32'(e2.k == K_DATA || e2.k == K_PC));
                chk("sb2_err_ovf", 32'(b2.err_ovf), 32'(e2.k == K_OVF));
                chk("sb2_err_udf", 32'(b2.err_udf), 32'(e2.k == K_UDF));
                if (e2.k == K_DATA) chk("sb2_rsp_data", 32'(b2.rsp_data), 32'(e2.d));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one step after the accepting edge, i.e. in cycle T+1.
    task automatic accept(input bit sel, input logic [1:0] op, input logic [15:0] d, input logic [31:0] pc);
        int n;
        n = 0;
        while (!(sel ? b2.req_ready : b1.req_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 20 cycles");
        end
        if (sel) begin
            b2.req_valid = 1'b1; b2.req_op = op; b2.req_data = d; b2.req_pc = pc;
        end else begin
            b1.req_valid = 1'b1; b1.req_op = op; b1.req_data = d; b1.req_pc = pc;
        end
        tick();
        b1.req_valid = 1'b0;
        b2.req_valid = 1'b0;
    endtask

    task automatic do_op(input bit sel, input logic [1:0] op, input logic [15:0] d, input logic [31:0] pc,
                         input logic [2:0] ek, input logic [15:0] ed, input logic [31:0] ep);
        exp_t e;
        e.k = ek; e.d = ed; e.pc = ep;
        if (ek != K_NONE) begin
            if (sel) q2.push_back(e);
            else q1.push_back(e);
        end
        accept(sel, op, d, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; flush = 1'b0;
        b1.req_valid = 1'b0; b1.req_op = 2'b00; b1.req_data = '0; b1.req_pc = '0;
        b2.req_valid = 1'b0; b2.req_op = 2'b00; b2.req_data = '0; b2.req_pc = '0;

        tbl[0]  = '{OP_POP,  16'h0,    32'h0,         K_UDF,  16'h0,    32'h0,         10'h3FF, 11'd0};
        tbl[1]  = '{OP_RET,  16'h0,    32'h0,         K_UDF,  16'h0,    32'h0,         10'h3FF, 11'd0};
        tbl[2]  = '{OP_PUSH, 16'h0001, 32'h0,         K_NONE, 16'h0,    32'h0,         10'h3FE, 11'd1};
        tbl[3]  = '{OP_RET,  16'h0,    32'h0,         K_UDF,  16'h0,    32'h0,         10'h3FE, 11'd1};
        tbl[4]  = '{OP_POP,  16'h0,    32'h0,         K_DATA, 16'h0001, 32'h0,         10'h3FF, 11'd0};
        tbl[5]  = '{OP_PUSH, 16'h1111, 32'h0,         K_NONE, 16'h0,    32'h0,         10'h3FE, 11'd1};
        tbl[6]  = '{OP_PUSH, 16'h2222, 32'h0,         K_NONE, 16'h0,    32'h0,         10'h3FD, 11'd2};
        tbl[7]  = '{OP_CALL, 16'h0,    32'hDEADBEEF,  K_NONE, 16'h0,    32'h0,         10'h3FB, 11'd4};
        tbl[8]  = '{OP_RET,  16'h0,    32'h0,         K_PC,   16'h0,    32'hDEADBEEF,  10'h3FD, 11'd2};
        tbl[9]  = '{OP_POP,  16'h0,    32'h0,         K_DATA, 16'h2222, 32'h0,         10'h3FE, 11'd1};
        tbl[10] = '{OP_POP,  16'h0,    32'h0,         K_DATA, 16'h1111, 32'h0,         10'h3FF, 11'd0};
        tbl[11] = '{OP_CALL, 16'h0,    32'h0BADF00D,  K_NONE, 16'h0,    32'h0,         10'h3FD, 11'd2};
        tbl[12] = '{OP_POP,  16'h0,    32'h0,         K_DATA, 16'hF00D, 32'h0,         10'h3FE, 11'd1};
        tbl[13] = '{OP_POP,  16'h0,    32'h0,         K_DATA, 16'h0BAD, 32'h0,         10'h3FF, 11'd0};

        repeat (3) tick();
        chk("rst_sp", 32'(sp1), 32'h3FF);
        chk("rst_depth", 32'(depth1), 32'd0);
        chk("rst_strobes", {27'd0, b1.mem_we, b1.mem_re, b1.rsp_valid, b1.err_ovf, b1.err_udf}, 32'd0);
        chk("rst_rsp_data", 32'(b1.rsp_data), 32'd0);
        chk("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_req_ready", 32'(b1.req_ready), 32'd1);

        do_op(1'b0, OP_PUSH, 16'hA5A5, 32'h0, K_NONE, 16'h0, 32'h0);
        chk("push_we", 32'(b1.mem_we), 32'd1);
        chk("push_addr", 32'(b1.mem_addr), 32'h3FF);
        chk("push_wdata", 32'(b1.mem_wdata), 32'hA5A5);
        chk("push_busy", 32'(b1.req_ready), 32'd0);
        tick();
        chk("push_sp", 32'(sp1), 32'h3FE);
        chk("push_depth", 32'(depth1), 32'd1);
        chk("push_we_off", 32'(b1.mem_we), 32'd0);

        do_op(1'b0, OP_POP, 16'h0, 32'h0, K_DATA, 16'hA5A5, 32'h0);
        chk("pop_re", 32'(b1.mem_re), 32'd1);
        chk("pop_addr", 32'(b1.mem_addr), 32'h3FF);
        tick();
        chk("pop_sp", 32'(sp1), 32'h3FF);
        chk("pop_rsp_early", 32'(b1.rsp_valid), 32'd0);
        tick();
        chk("pop_rsp_t3", 32'(b1.rsp_valid), 32'd1);
        chk("pop_ready_t3", 32'(b1.req_ready), 32'd1);

        do_op(1'b0, OP_CALL, 16'h0, 32'h12345678, K_NONE, 16'h0, 32'h0);
        chk("call_hi", {b1.mem_we, 5'd0, b1.mem_addr, b1.mem_wdata}, {1'b1, 5'd0, 10'h3FF, 16'h1234});
        tick();
        chk("call_lo", {b1.mem_we, 5'd0, b1.mem_addr, b1.mem_wdata}, {1'b1, 5'd0, 10'h3FE, 16'h5678});
        tick();
        chk("call_sp", 32'(sp1), 32'h3FD);
        chk("call_depth", 32'(depth1), 32'd2);

        do_op(1'b0, OP_RET, 16'h0, 32'h0, K_PC, 16'h0, 32'h12345678);
        chk("ret_rd_lo", {b1.mem_re, 21'd0, b1.mem_addr}, {1'b1, 21'd0, 10'h3FE});
        tick();
        chk("ret_rd_hi", {b1.mem_re, 21'd0, b1.mem_addr}, {1'b1, 21'd0, 10'h3FF});
        tick();
        chk("ret_rsp_early", 32'(b1.rsp_valid), 32'd0);
        tick();
        chk("ret_rsp_t4", 32'(b1.rsp_valid), 32'd1);
        chk("ret_sp", 32'(sp1), 32'h3FF);
        chk("ret_depth", 32'(depth1), 32'd0);

        for (int i = 0; i < 14; i++) begin
            do_op(1'b0, tbl[i].op, tbl[i].d, tbl[i].pc, tbl[i].ek, tbl[i].ed, tbl[i].ep);
            repeat (6) tick();
            chk($sformatf("tbl%0d_sp", i), 32'(sp1), 32'(tbl[i].esp));
            chk($sformatf("tbl%0d_depth", i), 32'(depth1), 32'(tbl[i].edep));
        end

        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, OP_PUSH, 16'hA000 + 16'(i), 32'h0, K_NONE, 16'h0, 32'h0);
            repeat (3) tick();
        end
        chk("aw2_full_depth", 32'(depth2), 32'd4);
        do_op(1'b1, OP_PUSH, 16'hBEEF, 32'h0, K_OVF, 16'h0, 32'h0);
        chk("aw2_ovf_pulse", 32'(b2.err_ovf), 32'd1);
        chk("aw2_ovf_no_we", 32'(b2.mem_we), 32'd0);
        repeat (3) tick();
        chk("aw2_ovf_depth", 32'(depth2), 32'd4);
        do_op(1'b1, OP_POP, 16'h0, 32'h0, K_DATA, 16'hA003, 32'h0);
        repeat (4) tick();
        do_op(1'b1, OP_CALL, 16'h0, 32'h55556666, K_OVF, 16'h0, 32'h0);
        chk("aw2_call_ovf_no_we", 32'(b2.mem_we), 32'd0);
        repeat (3) tick();
        chk("aw2_call_ovf_depth", 32'(depth2), 32'd3);
        for (int i = 2; i >= 0; i--) begin
            do_op(1'b1, OP_POP, 16'h0, 32'h0, K_DATA, 16'hA000 + 16'(i), 32'h0);
            repeat (4) tick();
        end
        do_op(1'b1, OP_POP, 16'h0, 32'h0, K_UDF, 16'h0, 32'h0);
        chk("aw2_udf_pulse", 32'(b2.err_udf), 32'd1);
        chk("aw2_udf_no_re", 32'(b2.mem_re), 32'd0);

        do_op(1'b0, OP_CALL, 16'h0, 32'hCAFEBEEF, K_NONE, 16'h0, 32'h0);
        chk("flush_hi_we", 32'(b1.mem_we), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_no_we", 32'(b1.mem_we), 32'd0);
        chk("flush_sp", 32'(sp1), 32'h3FF);
        chk("flush_depth", 32'(depth1), 32'd0);
        chk("flush_idle", 32'(b1.req_ready), 32'd1);
        repeat (4) tick();
        chk("flush_ram_hi", 32'(ram1[10'h3FF]), 32'hCAFE);
        chk("flush_ram_lo", 32'(ram1[10'h3FE]), 32'hF00D);

        do_op(1'b0, OP_CALL, 16'h0, 32'h11112222, K_NONE, 16'h0, 32'h0);
        repeat (3) tick();
        do_op(1'b0, OP_RET, 16'h0, 32'h0, K_NONE, 16'h0, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_sp", 32'(sp1), 32'h3FF);
        chk("arst_depth", 32'(depth1), 32'd0);
        chk("arst_strobes", {29'd0, b1.mem_we, b1.mem_re, b1.rsp_valid}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_ready", 32'(b1.req_ready), 32'd1);
        repeat (5) tick();

        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb2_drained", 32'(q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
